mac_accumulator: RTL and testbench

Sequential multiply-accumulate stage built around the `multiplier` core. It accepts a stream of unsigned operand pairs over a valid/ready handshake and registers each pair into the combinational `multiplier` instance. It registers the resulting product and sums the products into a dot-product result. The result is presented on a valid/ready output port, and the block is the consumer of `multiplier`'s `r` output in the datapath.

---
 rtl/mac_accumulator.sv | 160 ++++++++++++++++
 tb/tb_mac_accumulator.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// Multiply-accumulate stage: streams unsigned operand pairs through a two-stage
// pipeline around a combinational multiplier and emits one dot product per packet.

module multiplier #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] r
);
    logic [2*WIDTH-1:0] a_ext;

    assign a_ext = {{WIDTH{1'b0}}, a};

    // Shift-and-add array: row gi adds a<<gi when bit gi of b is set.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_row
            logic [2*WIDTH-1:0] row;
            logic [2*WIDTH-1:0] sum;
            assign row = b[gi] ? (a_ext << gi) : '0;
            if (gi == 0) begin : g_first
                assign sum = row;
            end else begin : g_rest
                assign sum = g_row[gi-1].sum + row;
            end
        end
    endgenerate

    assign r = g_row[WIDTH-1].sum;
endmodule

module mac_accumulator #(
    parameter int WIDTH = 10,
    parameter int LEN   = 16,
    localparam int ACC_W = 2*WIDTH + $clog2(LEN),
    localparam int CNT_W = $clog2(LEN+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count
);
    typedef enum logic [1:0] {ACCUM, FLUSH, HOLD} state_t;

    state_t               state_reg, state_next;
    logic                 in_ready_reg, in_ready_next;
    logic                 load_result, consume;

    logic [CNT_W-1:0]     cnt_reg;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 accept, terminating;

    logic [WIDTH-1:0]     s1_a_reg, s1_b_reg;
    logic                 s1_valid_reg, s1_last_reg;
    logic [2*WIDTH-1:0]   product;
    logic [2*WIDTH-1:0]   s2_prod_reg;
    logic                 s2_valid_reg, s2_last_reg;

    logic [ACC_W-1:0]     acc_reg, acc_sum;
    logic [ACC_W-1:0]     out_sum_reg;
    logic [CNT_W-1:0]     out_count_reg;

    assign accept      = in_valid && in_ready_reg;
    assign cnt_inc     = cnt_reg + 1'b1;
    // A beat terminates on in_last or when it is the LEN-th beat; both together count once.
    assign terminating = in_last || (cnt_inc == CNT_W'(LEN));
    assign acc_sum     = acc_reg + ACC_W'(s2_prod_reg);

    multiplier #(WIDTH) u_mult (
        .a (s1_a_reg),
        .b (s1_b_reg),
        .r (product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ACCUM;
            in_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= in_ready_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACCUM:   if (accept && terminating)        state_next = FLUSH;
            FLUSH:   if (s2_valid_reg && s2_last_reg)  state_next = HOLD;
            HOLD:    if (out_ready)                    state_next = ACCUM;
            default:                                   state_next = ACCUM;
        endcase
    end

    always_comb begin
        in_ready_next = (state_next == ACCUM);
        load_result   = (state_reg == FLUSH) && s2_valid_reg && s2_last_reg;
        consume       = (state_reg == HOLD) && out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a_reg      <= '0;
            s1_b_reg      <= '0;
            s1_valid_reg  <= 1'b0;
            s1_last_reg   <= 1'b0;
            s2_prod_reg   <= '0;
            s2_valid_reg  <= 1'b0;
            s2_last_reg   <= 1'b0;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            out_sum_reg   <= '0;
            out_count_reg <= '0;
        end else begin
            s1_valid_reg <= accept;
            s1_last_reg  <= accept && terminating;
            if (accept) begin
                s1_a_reg <= in_a;
                s1_b_reg <= in_b;
            end

            s2_valid_reg <= s1_valid_reg;
            s2_last_reg  <= s1_last_reg;
            if (s1_valid_reg) begin
                s2_prod_reg <= product;
            end

            if (consume) begin
                cnt_reg <= '0;
            end else if (accept) begin
                cnt_reg <= cnt_inc;
            end

            if (consume) begin
                acc_reg <= '0;
            end else if (s2_valid_reg) begin
                acc_reg <= acc_sum;
            end

            // The result register captures the sum including the terminating product.
            if (load_result) begin
                out_sum_reg   <= acc_sum;
                out_count_reg <= cnt_reg;
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = (state_reg == HOLD);
    assign out_sum   = out_sum_reg;
    assign out_count = out_count_reg;
endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: directed scenarios plus randomized packets checked
// against a sum-of-products model built from accepted beats.

module tb_mac_accumulator;
    localparam int WIDTH = 10;
    localparam int LEN   = 16;
    localparam int ACC_W = 2*WIDTH + $clog2(LEN);
    localparam int CNT_W = $clog2(LEN+1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;

    int     errors = 0;
    int     checks = 0;
    bit     rand_bp = 1'b0;
    longint cur_sum = 0;
    int     cur_cnt = 0;
    longint exp_sum_q[$];
    int     exp_cnt_q[$];
    logic   prev_valid = 1'b0;
    logic   prev_ready = 1'b0;

    mac_accumulator #(.WIDTH(WIDTH), .LEN(LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint expv);
        checks++;
        if (obs != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Reference: a packet is the run of accepted beats closed by in_last or the LEN-th beat.
    task automatic model_accept(input longint a, input longint b, input bit last);
        cur_sum += a * b;
        cur_cnt++;
        if (last || cur_cnt == LEN) begin
            exp_sum_q.push_back(cur_sum);
            exp_cnt_q.push_back(cur_cnt);
            $display("model: packet closed sum=%0d count=%0d", cur_sum, cur_cnt);
            cur_sum = 0;
            cur_cnt = 0;
        end
    endtask

    task automatic model_reset();
        cur_sum = 0;
        cur_cnt = 0;
        exp_sum_q.delete();
        exp_cnt_q.delete();
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic last);
        int w = 0;
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        while (!in_ready && w < 300) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end else begin
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
            model_accept(a, b, last);
        end
    endtask

    task automatic wait_valid(input string tag);
        int w = 0;
        while (!out_valid && w < 50) begin
            tick();
            w++;
        end
        check(tag, out_valid, 1);
    endtask

    // Output monitor: every handshake must deliver the oldest expected packet.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
            prev_ready <= 1'b0;
        end else begin
            if (prev_valid && !prev_ready) check("valid_held", out_valid, 1);
            if (out_valid && out_ready) begin
                check("result_pending", longint'(exp_sum_q.size() > 0), 1);
                if (exp_sum_q.size() > 0) begin
                    $display("result: sum=%0d count=%0d", out_sum, out_count);
                    check("mon_sum", out_sum, exp_sum_q.pop_front());
                    check("mon_count", out_count, exp_cnt_q.pop_front());
                end
            end
            prev_valid <= out_valid;
            prev_ready <= out_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held 3 cycles with in_valid asserted
        rst_n = 1'b0; in_valid = 1'b1; in_a = 5; in_b = 5;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_sum", out_sum, 0);
            check("rst_out_count", out_count, 0);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        check("release_in_ready_low", in_ready, 0);
        tick();
        check("release_in_ready_high", in_ready, 1);
        check("release_out_valid", out_valid, 0);

        // Full-length packet of maximum operands with timing of the result
        out_ready = 1'b1;
        for (int i = 0; i < LEN; i++) send(10'd1023, 10'd1023, 1'b0);
        check("full_t1_valid", out_valid, 0);
        check("full_t1_in_ready", in_ready, 0);
        tick();
        check("full_t2_valid", out_valid, 0);
        tick();
        check("full_t3_valid", out_valid, 1);
        check("full_sum", out_sum, 16744464);
        check("full_count", out_count, 16);
        tick();
        check("full_t4_valid", out_valid, 0);
        check("full_t4_in_ready", in_ready, 1);

        // Early last, then a single-beat packet
        send(3, 5, 1'b0);
        send(3, 5, 1'b0);
        send(3, 5, 1'b1);
        wait_valid("early_valid");
        check("early_sum", out_sum, 45);
        check("early_count", out_count, 3);
        tick();
        send(7, 9, 1'b1);
        wait_valid("single_valid");
        check("single_sum", out_sum, 63);
        check("single_count", out_count, 1);
        tick();

        // Backpressure: result stays put while out_ready is low
        out_ready = 1'b0;
        send(2, 3, 1'b1);
        wait_valid("bp_valid");
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_sum", out_sum, 6);
            check("bp_hold_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        check("bp_release_valid", out_valid, 1);
        tick();
        check("bp_after_valid", out_valid, 0);
        check("bp_after_in_ready", in_ready, 1);
        check("bp_after_sum_kept", out_sum, 6);

        // Bubbles between beats
        for (int i = 0; i < 4; i++) begin
            send(10, 10, (i == 3));
            if (i < 3) begin
                tick();
                tick();
            end
        end
        wait_valid("bubble_valid");
        check("bubble_sum", out_sum, 400);
        check("bubble_count", out_count, 4);
        tick();

        // Reset in the middle of a packet discards it
        for (int i = 0; i < 5; i++) send(100, 100, 1'b0);
        rst_n = 1'b0;
        model_reset();
        tick();
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        rst_n = 1'b1;
        send(2, 2, 1'b0);
        send(2, 2, 1'b1);
        wait_valid("midrst_valid");
        check("midrst_sum", out_sum, 8);
        check("midrst_count", out_count, 2);
        tick();

        // Randomized packets with random gaps and random backpressure
        rand_bp = 1'b1;
        for (int d = 0; d < 25; d++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int k = 0; k < len; k++) begin
                logic [WIDTH-1:0] ra, rb;
                logic             rl;
                ra = ($urandom_range(0, 7) == 0) ? 10'd1023 : WIDTH'($urandom);
                rb = ($urandom_range(0, 7) == 0) ? 10'd1023 : WIDTH'($urandom);
                rl = (k == len - 1) && ($urandom_range(0, 3) != 0);
                send(ra, rb, rl);
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        send(1, 1, 1'b1);
        rand_bp = 1'b0;
        out_ready = 1'b1;
        for (int w = 0; w < 100 && exp_sum_q.size() > 0; w++) tick();
        tick();
        check("drain_empty", exp_sum_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
